// File: rtl/conv_neur_accum.sv
// Membrane accumulator and threshold sweep for one convolution EC lane.
// Define CONV_NEUR_LEAK_EN to build the leaky (LIF) sweep variant.
module conv_neur_accum #(
    parameter int OUTPUT_FRAME_WIDTH = 26,
    parameter int WEIGHT_WIDTH       = 8,
    parameter int MEMBR_WIDTH        = 16,
    parameter int THRESHOLD          = 64,
    parameter int LEAK_SHIFT         = 3,
    localparam int N  = OUTPUT_FRAME_WIDTH * OUTPUT_FRAME_WIDTH,
    localparam int AW = $clog2(OUTPUT_FRAME_WIDTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           accum_valid,
    input  logic                           neur_addr_invalid,
    input  logic [AW-1:0]                  addr_y,
    input  logic [AW-1:0]                  addr_x,
    input  logic signed [WEIGHT_WIDTH-1:0] weight,
    input  logic                           activ_start,
    input  logic                           membr_clear,
    output logic                           busy,
    output logic [N-1:0]                   spk_out,
    output logic                           spk_out_valid,
    output logic                           drop_err
);

    localparam int IW = $clog2(N);
    localparam int MW = MEMBR_WIDTH;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic signed [MW-1:0] TH = MW'(THRESHOLD);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCUM, S_DRAIN, S_SWEEP, S_CLEAR
    } state_t;

    state_t r_state, w_next;

    logic signed [MW-1:0] r_mem [N];
    logic signed [MW-1:0] r_rd;

    logic                 r_s1_v, r_s2_v, r_s3_v;
    logic [IW-1:0]        r_s1_idx, r_s2_idx, r_s3_idx;
    logic signed [MW-1:0] r_s1_w, r_s2_sum, r_s3_sum;

    logic [IW-1:0] r_cnt, r_sw_idx;
    logic          r_rd_done, r_sw_v;
    logic [N-1:0]  r_frame, r_spk;
    logic          r_valid, r_drop;

    logic                 w_busy, w_accept, w_go_clear;
    logic [IW-1:0]        w_idx, w_rd_addr, w_wr_addr;
    logic signed [MW-1:0] w_wext, w_op, w_sat, w_wr_data;
    logic signed [MW:0]   w_sum;
    logic                 w_wr_en, w_issue, w_sw_wr, w_last_wr, w_fire;
    logic signed [MW-1:0] w_base, w_sw_new;
    logic [N-1:0]         w_frame;

    assign w_busy = (r_state == S_DRAIN) || (r_state == S_SWEEP)
                 || (r_state == S_CLEAR);
    assign w_go_clear = !w_busy && membr_clear;
    assign w_accept = accum_valid && !neur_addr_invalid && !w_busy
                   && !membr_clear
                   && (int'(addr_y) < OUTPUT_FRAME_WIDTH)
                   && (int'(addr_x) < OUTPUT_FRAME_WIDTH);
    assign w_idx = IW'(addr_y) * IW'(OUTPUT_FRAME_WIDTH) + IW'(addr_x);
    assign w_wext = {{(MW-WEIGHT_WIDTH){weight[WEIGHT_WIDTH-1]}}, weight};

    // Newest pending sum wins over stale array data for the same neuron.
    assign w_op = (r_s2_v && r_s2_idx == r_s1_idx) ? r_s2_sum :
                  (r_s3_v && r_s3_idx == r_s1_idx) ? r_s3_sum : r_rd;
    assign w_sum = {w_op[MW-1], w_op} + {r_s1_w[MW-1], r_s1_w};
    assign w_sat = (w_sum[MW] ^ w_sum[MW-1])
                 ? {w_sum[MW], {(MW-1){~w_sum[MW]}}} : w_sum[MW-1:0];

    assign w_issue   = (r_state == S_SWEEP) && !r_rd_done;
    assign w_sw_wr   = (r_state == S_SWEEP) && r_sw_v;
    assign w_last_wr = w_sw_wr && (r_sw_idx == LAST);
    assign w_rd_addr = (r_state == S_SWEEP) ? r_cnt : w_idx;

    assign w_fire = (r_rd >= TH);
    assign w_base = w_fire ? r_rd - TH : r_rd;
`ifdef CONV_NEUR_LEAK_EN
    assign w_sw_new = w_base - (w_base >>> LEAK_SHIFT);
`else
    assign w_sw_new = w_base;
`endif

    always_comb begin
        w_frame = r_frame;
        w_frame[r_sw_idx] = w_fire;
    end

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_s2_idx;
        w_wr_data = r_s2_sum;
        if (r_state == S_CLEAR) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_cnt;
            w_wr_data = '0;
        end else if (w_sw_wr) begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_sw_idx;
            w_wr_data = w_sw_new;
        end else if (r_s2_v) begin
            w_wr_en = 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_ACCUM: begin
                if (membr_clear)
                    w_next = S_CLEAR;
                else if (activ_start)
                    w_next = S_DRAIN;
                else if (w_accept || r_s1_v)
                    w_next = S_ACCUM;
                else
                    w_next = S_IDLE;
            end
            S_DRAIN: if (!r_s1_v && !r_s2_v) w_next = S_SWEEP;
            S_SWEEP: if (w_last_wr) w_next = S_IDLE;
            S_CLEAR: if (r_cnt == LAST) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[w_wr_addr] <= w_wr_data;
        r_rd <= r_mem[w_rd_addr];
    end

    // A clear discards in-flight requests; the array is zeroed anyway.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_v   <= 1'b0;
            r_s2_v   <= 1'b0;
            r_s3_v   <= 1'b0;
            r_s1_idx <= '0;
            r_s2_idx <= '0;
            r_s3_idx <= '0;
            r_s1_w   <= '0;
            r_s2_sum <= '0;
            r_s3_sum <= '0;
        end else begin
            r_s1_v   <= w_accept;
            r_s1_idx <= w_idx;
            r_s1_w   <= w_wext;
            r_s2_v   <= r_s1_v && !w_go_clear;
            r_s2_idx <= r_s1_idx;
            r_s2_sum <= w_sat;
            r_s3_v   <= r_s2_v && !w_go_clear;
            r_s3_idx <= r_s2_idx;
            r_s3_sum <= r_s2_sum;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rd_done <= 1'b0;
            r_sw_v    <= 1'b0;
            r_sw_idx  <= '0;
            r_frame   <= '0;
            r_spk     <= '0;
            r_valid   <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state != w_next)
                r_cnt <= '0;
            else if (w_issue || r_state == S_CLEAR)
                r_cnt <= r_cnt + 1'b1;
            if (r_state != w_next)
                r_rd_done <= 1'b0;
            else if (w_issue && r_cnt == LAST)
                r_rd_done <= 1'b1;
            r_sw_v   <= w_issue;
            r_sw_idx <= r_cnt;
            if (w_sw_wr)
                r_frame <= w_frame;
            r_valid <= w_last_wr;
            if (w_last_wr)
                r_spk <= w_frame;
            r_drop <= r_drop || (accum_valid && w_busy);
        end
    end

    assign busy          = w_busy;
    assign spk_out       = r_spk;
    assign spk_out_valid = r_valid;
    assign drop_err      = r_drop;

endmodule

// File: tb/tb_conv_neur_accum.sv
// Scoreboard bench for conv_neur_accum; honours CONV_NEUR_LEAK_EN.
`timescale 1ns/1ps
module tb_conv_neur_accum;

    localparam int W  = 26;
    localparam int N  = W * W;
    localparam int AW = $clog2(W);
    localparam int TH = 64;
    localparam int LS = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic accum_valid = 1'b0;
    logic neur_addr_invalid = 1'b0;
    logic [AW-1:0] addr_y = '0;
    logic [AW-1:0] addr_x = '0;
    logic signed [7:0] weight = '0;
    logic activ_start = 1'b0;
    logic membr_clear = 1'b0;
    logic busy, spk_out_valid, drop_err;
    logic [N-1:0] spk_out;

    int n_pass = 0;
    int n_total = 0;
    int model [N];
    logic [N-1:0] exp_q [$];

    conv_neur_accum dut (
        .clk(clk), .rst(rst),
        .accum_valid(accum_valid),
        .neur_addr_invalid(neur_addr_invalid),
        .addr_y(addr_y), .addr_x(addr_x), .weight(weight),
        .activ_start(activ_start), .membr_clear(membr_clear),
        .busy(busy), .spk_out(spk_out),
        .spk_out_valid(spk_out_valid), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) model[i] = 0;
    endtask

    task automatic sweep_model(output logic [N-1:0] f);
        int b;
        f = '0;
        for (int i = 0; i < N; i++) begin
            b = model[i];
            if (b >= TH) begin
                f[i] = 1'b1;
                b = b - TH;
            end
`ifdef CONV_NEUR_LEAK_EN
            b = b - (b >>> LS);
`endif
            model[i] = b;
        end
    endtask

    task automatic send(input int y, input int x, input int w, input bit inv);
        accum_valid = 1'b1;
        neur_addr_invalid = inv;
        addr_y = AW'(y);
        addr_x = AW'(x);
        weight = 8'(w);
        if (!inv && y < W && x < W)
            model[y*W+x] = sat(model[y*W+x] + w);
        @(posedge clk); #1;
        accum_valid = 1'b0;
        neur_addr_invalid = 1'b0;
    endtask

    task automatic clear_dut();
        int n;
        membr_clear = 1'b1;
        @(posedge clk); #1;
        membr_clear = 1'b0;
        n = 0;
        while (busy && n < N + 10) begin @(posedge clk); #1; n++; end
        clear_model();
    endtask

    task automatic run_sweep(output logic [N-1:0] got, output int lat,
                             output logic b1, output logic bv,
                             output logic va);
        logic [N-1:0] e;
        sweep_model(e);
        exp_q.push_back(e);
        activ_start = 1'b1;
        @(posedge clk); #1;
        activ_start = 1'b0;
        b1 = busy;
        lat = 1;
        while (!spk_out_valid && lat < N + 50) begin
            @(posedge clk); #1;
            lat++;
        end
        got = spk_out;
        bv = busy;
        @(posedge clk); #1;
        va = spk_out_valid;
    endtask

    task automatic test_reset();
        idle(3);
        n_total++;
        if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
        else n_pass++;
        n_total++;
        if (spk_out !== '0) $display("FAIL rst_spk: got %h want 0", spk_out);
        else n_pass++;
        n_total++;
        if (spk_out_valid !== 1'b0)
            $display("FAIL rst_valid: got %b want 0", spk_out_valid);
        else n_pass++;
        rst = 1'b1;
        idle(2);
        n_total++;
        if (drop_err !== 1'b0 || busy !== 1'b0)
            $display("FAIL post_rst: drop %b busy %b want 0 0", drop_err, busy);
        else n_pass++;
    endtask

    task automatic test_clear();
        int n;
        logic b1;
        membr_clear = 1'b1;
        @(posedge clk); #1;
        membr_clear = 1'b0;
        b1 = busy;
        n = 0;
        while (busy && n < N + 10) begin @(posedge clk); #1; n++; end
        clear_model();
        n_total++;
        if (b1 !== 1'b1) $display("FAIL clr_busy_rise: got %b want 1", b1);
        else n_pass++;
        n_total++;
        if (n !== N) $display("FAIL clr_len: got %0d want %0d", n, N);
        else n_pass++;
        n_total++;
        if (spk_out !== '0) $display("FAIL clr_spk: got %h want 0", spk_out);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [N-1:0] got, e, e55;
        int lat;
        logic b1, bv, va;
        e55 = '0;
        e55[55] = 1'b1;
        send(2, 3, 70, 0);
        idle(3);
        run_sweep(got, lat, b1, bv, va);
        e = exp_q.pop_front();
        n_total++;
        if (got !== e) $display("FAIL basic_frame: got %h want %h", got, e);
        else n_pass++;
        n_total++;
        if (got !== e55) $display("FAIL basic_bit55: got %h want %h", got, e55);
        else n_pass++;
        n_total++;
        if (lat !== N + 3) $display("FAIL basic_lat: got %0d want %0d", lat, N + 3);
        else n_pass++;
        n_total++;
        if (b1 !== 1'b1 || bv !== 1'b0)
            $display("FAIL basic_busy: rise %b at_valid %b want 1 0", b1, bv);
        else n_pass++;
        n_total++;
        if (va !== 1'b0) $display("FAIL basic_pulse: got %b want 0", va);
        else n_pass++;
        run_sweep(got, lat, b1, bv, va);
        e = exp_q.pop_front();
        n_total++;
        if (got !== e) $display("FAIL basic_frame2: got %h want %h", got, e);
        else n_pass++;
        n_total++;
        if (int'(dut.r_mem[55]) !== model[55])
            $display("FAIL basic_resid: got %0d want %0d",
                     int'(dut.r_mem[55]), model[55]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] got, e;
        int lat;
        logic b1, bv, va;
        clear_dut();
        send(0, 0, 30, 0);
        send(0, 0, 30, 0);
        send(0, 0, 30, 0);
        run_sweep(got, lat, b1, bv, va);
        e = exp_q.pop_front();
        n_total++;
        if (got !== e) $display("FAIL b2b_frame: got %h want %h", got, e);
        else n_pass++;
        n_total++;
        if (lat < N + 3 || lat > N + 5)
            $display("FAIL b2b_lat: got %0d want %0d..%0d", lat, N + 3, N + 5);
        else n_pass++;
        n_total++;
        if (int'(dut.r_mem[0]) !== model[0])
            $display("FAIL b2b_resid: got %0d want %0d", int'(dut.r_mem[0]), model[0]);
        else n_pass++;
        send(5, 5, 10, 0);
        send(5, 6, 20, 0);
        send(5, 5, 15, 0);
        send(5, 6, -7, 0);
        idle(4);
        n_total++;
        if (int'(dut.r_mem[135]) !== 25 || int'(dut.r_mem[136]) !== 13)
            $display("FAIL fwd_gap: got %0d %0d want 25 13",
                     int'(dut.r_mem[135]), int'(dut.r_mem[136]));
        else n_pass++;
    endtask

    task automatic test_saturation();
        clear_dut();
        repeat (600) send(0, 0, 127, 0);
        idle(3);
        n_total++;
        if (int'(dut.r_mem[0]) !== 32767)
            $display("FAIL sat_pos: got %0d want 32767", int'(dut.r_mem[0]));
        else n_pass++;
        repeat (600) send(0, 0, -128, 0);
        idle(3);
        n_total++;
        if (int'(dut.r_mem[0]) !== -32768)
            $display("FAIL sat_neg: got %0d want -32768", int'(dut.r_mem[0]));
        else n_pass++;
        n_total++;
        if (model[0] !== -32768)
            $display("FAIL sat_model: got %0d want -32768", model[0]);
        else n_pass++;
    endtask

    task automatic test_discard();
        logic [N-1:0] got, e;
        int lat;
        logic b1, bv, va;
        clear_dut();
        send(1, 1, 100, 1);
        send(0, 26, 100, 0);
        send(26, 0, 100, 0);
        idle(4);
        n_total++;
        if (drop_err !== 1'b0) $display("FAIL disc_drop: got %b want 0", drop_err);
        else n_pass++;
        n_total++;
        if (int'(dut.r_mem[27]) !== 0 || int'(dut.r_mem[26]) !== 0)
            $display("FAIL disc_mem: got %0d %0d want 0 0",
                     int'(dut.r_mem[27]), int'(dut.r_mem[26]));
        else n_pass++;
        run_sweep(got, lat, b1, bv, va);
        e = exp_q.pop_front();
        n_total++;
        if (got !== e) $display("FAIL disc_frame: got %h want %h", got, e);
        else n_pass++;
    endtask

    task automatic test_drop();
        logic [N-1:0] got, e;
        int lat;
        logic b1, bv, va;
        clear_dut();
        send(1, 2, 64, 0);
        idle(2);
        sweep_model(e);
        exp_q.push_back(e);
        activ_start = 1'b1;
        @(posedge clk); #1;
        activ_start = 1'b0;
        lat = 1;
        idle(10);
        lat += 10;
        accum_valid = 1'b1;
        addr_y = '0;
        addr_x = '0;
        weight = 8'sd100;
        activ_start = 1'b1;
        membr_clear = 1'b1;
        @(posedge clk); #1;
        lat++;
        accum_valid = 1'b0;
        activ_start = 1'b0;
        membr_clear = 1'b0;
        n_total++;
        if (drop_err !== 1'b1 || busy !== 1'b1)
            $display("FAIL drop_set: drop %b busy %b want 1 1", drop_err, busy);
        else n_pass++;
        while (!spk_out_valid && lat < N + 50) begin
            @(posedge clk); #1;
            lat++;
        end
        got = spk_out;
        e = exp_q.pop_front();
        n_total++;
        if (got !== e) $display("FAIL drop_frame: got %h want %h", got, e);
        else n_pass++;
        n_total++;
        if (lat !== N + 3) $display("FAIL drop_lat: got %0d want %0d", lat, N + 3);
        else n_pass++;
        run_sweep(got, lat, b1, bv, va);
        e = exp_q.pop_front();
        n_total++;
        if (got !== e) $display("FAIL drop_after: got %h want %h", got, e);
        else n_pass++;
        n_total++;
        if (drop_err !== 1'b1) $display("FAIL drop_sticky: got %b want 1", drop_err);
        else n_pass++;
    endtask

    task automatic test_priority();
        logic [N-1:0] got, e;
        int lat, n;
        logic b1, bv, va, seen;
        send(3, 3, 100, 0);
        idle(2);
        membr_clear = 1'b1;
        activ_start = 1'b1;
        @(posedge clk); #1;
        membr_clear = 1'b0;
        activ_start = 1'b0;
        n = 0;
        seen = 1'b0;
        while (busy && n < N + 10) begin
            if (spk_out_valid) seen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        clear_model();
        n_total++;
        if (n !== N || seen !== 1'b0)
            $display("FAIL prio_clear: len %0d valid %b want %0d 0", n, seen, N);
        else n_pass++;
        run_sweep(got, lat, b1, bv, va);
        e = exp_q.pop_front();
        n_total++;
        if (got !== e) $display("FAIL prio_frame: got %h want %h", got, e);
        else n_pass++;
    endtask

`ifdef CONV_NEUR_LEAK_EN
    task automatic test_leak();
        logic [N-1:0] got, e;
        int lat;
        logic b1, bv, va;
        clear_dut();
        send(0, 1, 40, 0);
        idle(3);
        run_sweep(got, lat, b1, bv, va);
        e = exp_q.pop_front();
        n_total++;
        if (got !== e || int'(dut.r_mem[1]) !== 35)
            $display("FAIL leak1: mem %0d want 35", int'(dut.r_mem[1]));
        else n_pass++;
        run_sweep(got, lat, b1, bv, va);
        e = exp_q.pop_front();
        n_total++;
        if (got !== e || int'(dut.r_mem[1]) !== 31)
            $display("FAIL leak2: mem %0d want 31", int'(dut.r_mem[1]));
        else n_pass++;
    endtask
`endif

    task automatic test_reset_mid();
        send(0, 0, 100, 0);
        idle(2);
        activ_start = 1'b1;
        @(posedge clk); #1;
        activ_start = 1'b0;
        idle(100);
        n_total++;
        if (busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy);
        else n_pass++;
        rst = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (busy !== 1'b0 || spk_out_valid !== 1'b0)
            $display("FAIL mid_abort: busy %b valid %b want 0 0",
                     busy, spk_out_valid);
        else n_pass++;
        n_total++;
        if (spk_out !== '0 || drop_err !== 1'b0)
            $display("FAIL mid_state: spk %h drop %b want 0 0", spk_out, drop_err);
        else n_pass++;
        idle(3);
    endtask

    initial begin
        clear_model();
        test_reset();
        test_clear();
        test_basic();
        test_back_to_back();
        test_saturation();
        test_discard();
        test_drop();
        test_priority();
`ifdef CONV_NEUR_LEAK_EN
        test_leak();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/conv_neur_accum.md
# conv_neur_accum

Downstream neural stage of the convolution event controller. Consumes per-spike affected-neuron coordinates with their kernel weight, accumulates them into a membrane-potential array for one output channel, then runs a threshold sweep that emits the post-synaptic spike frame for the current time step. One instance serves one EC lane.

## Interface
Parameters:
- OUTPUT_FRAME_WIDTH, 26, output feature-map width/height; N = OUTPUT_FRAME_WIDTH² neurons.
- WEIGHT_WIDTH, 8, signed kernel weight width.
- MEMBR_WIDTH, 16, signed membrane-potential width.
- THRESHOLD, 64, firing threshold (positive, fits MEMBR_WIDTH).
- LEAK_SHIFT, 3, leak divisor exponent (used only with leak compiled in).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- accum_valid  in  1  accumulate request (driven by controller's en_accum).
- neur_addr_invalid  in  1  request targets an out-of-frame neuron; discard.
- addr_y, addr_x  in  $clog2(OUTPUT_FRAME_WIDTH) each  affected neuron coordinates.
- weight  in  WEIGHT_WIDTH  signed weight aligned with the request.
- activ_start  in  1  one-cycle pulse: start threshold sweep.
- membr_clear  in  1  one-cycle pulse: zero all membranes (new image).
- busy  out  1  sweep or clear in progress.
- spk_out  out  N  spike frame, bit i = neuron y*W+x.
- spk_out_valid  out  1  one-cycle pulse: spk_out updated.
- drop_err  out  1  sticky: a request arrived while busy.

## Operation
- Storage: N×MEMBR_WIDTH membrane array, synchronous read, one read and one write port.
- Accumulate pipeline (only when busy=0):
  - S0: accept when accum_valid=1 and neur_addr_invalid=0 and addr_y,addr_x < OUTPUT_FRAME_WIDTH. Compute idx = addr_y*OUTPUT_FRAME_WIDTH+addr_x. Sign-extend the weight.
  - S1: read membrane[idx].
  - S2: sum = membrane + weight, saturated to the signed MEMBR_WIDTH range. Write it back.
  - Hazard: if S1/S2 idx equals an older in-flight idx, forward the newest pending sum instead of the array value. Back-to-back requests to the same neuron must accumulate exactly.
- FSM states: IDLE, ACCUM (pipeline non-empty), DRAIN, SWEEP, CLEAR.
  - activ_start in IDLE/ACCUM → DRAIN. Wait for the pipeline to empty, then SWEEP.
  - SWEEP: i = 0..N-1, one neuron per cycle, pipelined. If m ≥ THRESHOLD, set spike bit i and write m−THRESHOLD (reset by subtraction). Otherwise clear bit i and write m unchanged.
  - After the last write, latch the frame into spk_out, pulse spk_out_valid, go to IDLE.
  - membr_clear → CLEAR. Write 0 to every address, one per cycle, then IDLE. spk_out is not changed.
- busy=1 in DRAIN, SWEEP and CLEAR. accum_valid during busy is dropped and sets drop_err. drop_err is cleared only by reset.
- activ_start or membr_clear while busy: ignored.
- Simultaneous activ_start and membr_clear: membr_clear wins.

## Timing
- Accumulate: request at cycle t → array write at t+2. Throughput 1 request/cycle.
- Sweep: activ_start at t with an empty pipeline → busy from t+1 → spk_out_valid at t+N+3 → busy falls the same cycle. A non-empty pipeline adds up to 2 drain cycles.
- Clear: membr_clear at t → busy for N cycles → busy falls at t+N+1.
- Reset values: busy=0, spk_out=0, spk_out_valid=0, drop_err=0, FSM=IDLE, pipeline empty. The membrane array is not reset; the controller issues membr_clear after reset.
- Reset asserted mid-sweep or mid-clear: abort immediately. spk_out stays 0 and no valid pulse is issued.

## Configuration
- CONV_NEUR_LEAK_EN defined: LIF mode. In SWEEP, non-firing neurons write m − (m >>> LEAK_SHIFT) (arithmetic shift). Firing neurons write (m−THRESHOLD) − ((m−THRESHOLD) >>> LEAK_SHIFT).
- Undefined: pure integrate-and-fire as described in Operation, with no leak logic synthesised.

## Test plan
- Reset → membr_clear, then one request (y=2, x=3, w=+70) and activ_start → spk_out bit 55 only = 1, spk_out_valid once. A second sweep fires nothing (residual 6).
- Back-to-back same neuron (0,0) with w = +30, +30, +30 → 90 → fires; residual 26 after sweep (IF mode).
- Saturation: 600 requests of w=+127 to neuron 0 → membrane saturates at 32767, no wrap. Negative requests saturate at −32768.
- Requests with neur_addr_invalid=1, or x=26 → no membrane change, drop_err stays 0. A request during SWEEP → drop_err=1.
- CONV_NEUR_LEAK_EN, LEAK_SHIFT=3: neuron at 40, two sweeps → 35 then 31, no spikes.
- Reset asserted at sweep cycle 100 → busy=0 and spk_out_valid=0 the following cycle.
